rf_regbank: RTL and testbench

//  32-entry register storage array of the register file. Sits directly downstream of the 5->32 write-address decoder.

---
 rtl/rf_regbank_if.sv | 24 ++
 rtl/rf_regbank.sv | 67 ++++++
 tb/tb_rf_regbank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_regbank_if.sv
// Write/read bundle between the write-address decoder, the register bank and its operand readers.
// The master drives write controls and read addresses; the slave returns read data and the sticky select error.
interface rf_regbank_if #(
    parameter int WIDTH = 32
);
    logic             reg_write;
    logic [31:0]      w_sel;
    logic [WIDTH-1:0] w_data;
    logic [4:0]       r_addr1;
    logic [4:0]       r_addr2;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic             sel_err;

    modport master (
        output reg_write, w_sel, w_data, r_addr1, r_addr2,
        input  r_data1, r_data2, sel_err
    );

    modport slave (
        input  reg_write, w_sel, w_data, r_addr1, r_addr2,
        output r_data1, r_data2, sel_err
    );
endinterface

// File: rtl/rf_regbank.sv
// 32-entry register array with one-hot write port and two combinational read ports (optional write bypass).
// Writes commit 1 clock after presentation, reads are 0-latency; always ready, no backpressure.
module rf_regbank #(
    parameter int WIDTH    = 32,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_regbank_if.slave  bus
);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic             sel_err_q;
    logic             sel_err_d;

    logic             sel_any;
    logic             sel_multi;
    logic             wr_vld;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    // Clearing the lowest set bit leaves something behind only for a multi-hot vector.
    // Gating with rst_n keeps the bypass path from leaking w_data while reset is held.
    always_comb begin
        sel_any   = (bus.w_sel != 32'd0);
        sel_multi = ((bus.w_sel & (bus.w_sel - 32'd1)) != 32'd0);
        wr_vld    = rst_n && bus.reg_write && sel_any && !sel_multi
                    && !(ZERO_REG && bus.w_sel[0]);
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_vld) begin
            for (int i = 0; i < 32; i++) begin
                if (bus.w_sel[i]) regs_d[i] = bus.w_data;
            end
        end
        sel_err_d = sel_err_q | (bus.reg_write & sel_multi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '{default: '0};
            sel_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        rd1 = regs_q[bus.r_addr1];
        if (BYPASS && wr_vld && bus.w_sel[bus.r_addr1]) rd1 = bus.w_data;
        if (ZERO_REG && (bus.r_addr1 == 5'd0)) rd1 = '0;

        rd2 = regs_q[bus.r_addr2];
        if (BYPASS && wr_vld && bus.w_sel[bus.r_addr2]) rd2 = bus.w_data;
        if (ZERO_REG && (bus.r_addr2 == 5'd0)) rd2 = '0;
    end

    assign bus.r_data1 = rd1;
    assign bus.r_data2 = rd2;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_rf_regbank.sv
// Bench for rf_regbank: two instances (bypass+zero-reg, and plain) share one stimulus stream
// and are compared against an array-based model of the register file.
module tb_rf_regbank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_regbank_if #(.WIDTH(32)) bus_a ();
    rf_regbank_if #(.WIDTH(32)) bus_b ();

    assign bus_b.reg_write = bus_a.reg_write;
    assign bus_b.w_sel     = bus_a.w_sel;
    assign bus_b.w_data    = bus_a.w_data;
    assign bus_b.r_addr1   = bus_a.r_addr1;
    assign bus_b.r_addr2   = bus_a.r_addr2;

    rf_regbank #(.WIDTH(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    rf_regbank #(.WIDTH(32), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic        rw;
        logic [31:0] sel;
        logic [31:0] data;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_err;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Model: index 0 mirrors u_dut_a (bypass, zero reg), index 1 mirrors u_dut_b.
    logic [31:0] mem [2][32];
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
        m_err = 1'b0;
    endtask

    function automatic bit m_valid(int k);
        if (!bus_a.reg_write || $countones(bus_a.w_sel) != 1) return 1'b0;
        if (k == 0 && bus_a.w_sel[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(int k, logic [4:0] a);
        if (k == 0 && a == 5'd0) return 32'd0;
        if (k == 0 && m_valid(k) && bus_a.w_sel[a]) return bus_a.w_data;
        return mem[k][a];
    endfunction

    task automatic m_commit();
        if (bus_a.reg_write && $countones(bus_a.w_sel) > 1) m_err = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (m_valid(k)) begin
                for (int i = 0; i < 32; i++)
                    if (bus_a.w_sel[i]) mem[k][i] = bus_a.w_data;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        bus_a.reg_write = v.rw;
        bus_a.w_sel     = v.sel;
        bus_a.w_data    = v.data;
        bus_a.r_addr1   = v.a1;
        bus_a.r_addr2   = v.a2;
    endtask

    task automatic model_checks(input string tag);
        chk({tag, " a.r1"}, bus_a.r_data1, m_read(0, bus_a.r_addr1));
        chk({tag, " a.r2"}, bus_a.r_data2, m_read(0, bus_a.r_addr2));
        chk({tag, " b.r1"}, bus_b.r_data1, m_read(1, bus_a.r_addr1));
        chk({tag, " b.r2"}, bus_b.r_data2, m_read(1, bus_a.r_addr2));
        chk({tag, " a.err"}, {31'd0, bus_a.sel_err}, {31'd0, m_err});
        chk({tag, " b.err"}, {31'd0, bus_b.sel_err}, {31'd0, m_err});
    endtask

    // Called just after a falling edge; leaves time just after the next falling edge.
    task automatic cycle(input vec_t v, input bit use_tbl, input string tag);
        drive(v);
        #1;
        if (use_tbl) begin
            chk({tag, " tbl.r1"}, bus_a.r_data1, v.exp1);
            chk({tag, " tbl.r2"}, bus_a.r_data2, v.exp2);
            chk({tag, " tbl.err"}, {31'd0, bus_a.sel_err}, {31'd0, v.exp_err});
        end
        model_checks(tag);
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    function automatic vec_t rand_vec(input bit allow_multi);
        vec_t v;
        int   kind;
        int   b0;
        int   b1;
        v.rw   = ($urandom_range(0, 3) != 0);
        v.data = $urandom;
        kind   = $urandom_range(0, 19);
        b0     = $urandom_range(0, 31);
        b1     = (b0 + $urandom_range(1, 31)) % 32;
        if (kind == 0)                       v.sel = 32'd0;
        else if (kind == 1 && allow_multi)   v.sel = (32'd1 << b0) | (32'd1 << b1);
        else if (kind == 2 && !v.rw)         v.sel = $urandom;
        else                                 v.sel = 32'd1 << b0;
        v.a1 = ($urandom_range(0, 2) == 0) ? 5'(b0) : 5'($urandom_range(0, 31));
        v.a2 = ($urandom_range(0, 2) == 0) ? 5'(b0) : 5'($urandom_range(0, 31));
        v.exp1 = 32'd0;
        v.exp2 = 32'd0;
        v.exp_err = 1'b0;
        return v;
    endfunction

    vec_t tbl [10];
    vec_t rv;

    initial begin
        //        rw    sel            data           a1  a2  exp1           exp2           err
        tbl[0] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5,  0,  32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h0000_0000, 32'h0,         5,  5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0080, 32'h1234_5678, 7,  7,  32'h1234_5678, 32'h1234_5678, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 0,  7,  32'h0,         32'h1234_5678, 1'b0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 0,  31, 32'h0,         32'h0,         1'b0};
        tbl[5] = '{1'b0, 32'h0000_0000, 32'h0,         1,  2,  32'h0,         32'h0,         1'b0};
        tbl[6] = '{1'b1, 32'h0000_0006, 32'hAAAA_AAAA, 1,  2,  32'h0,         32'h0,         1'b0};
        tbl[7] = '{1'b1, 32'h0000_0000, 32'hAAAA_AAAA, 1,  2,  32'h0,         32'h0,         1'b1};
        tbl[8] = '{1'b1, 32'h0000_0008, 32'h0BAD_F00D, 3,  5,  32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b1};
        tbl[9] = '{1'b0, 32'h0000_0000, 32'h0,         3,  7,  32'h0BAD_F00D, 32'h1234_5678, 1'b1};

        rst_n = 1'b0;
        bus_a.reg_write = 1'b0;
        bus_a.w_sel     = 32'd0;
        bus_a.w_data    = 32'd0;
        bus_a.r_addr1   = 5'd5;
        bus_a.r_addr2   = 5'd31;
        m_clear();
        #1;
        chk("reset a.r1", bus_a.r_data1, 32'd0);
        chk("reset b.r2", bus_b.r_data2, 32'd0);
        chk("reset a.err", {31'd0, bus_a.sel_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        for (int i = 0; i < 250; i++) begin
            rv = rand_vec(1'b0);
            cycle(rv, 1'b0, "rand1");
        end

        // Load reg 31, then reset mid-cycle with another write to it pending.
        rv = '{1'b1, 32'h8000_0000, 32'hCAFE_0001, 31, 31, 32'h0, 32'h0, 1'b0};
        cycle(rv, 1'b0, "load31");
        rv = '{1'b1, 32'h8000_0000, 32'h1111_1111, 31, 31, 32'h0, 32'h0, 1'b0};
        drive(rv);
        #1;
        chk("pend a.r1", bus_a.r_data1, 32'h1111_1111);
        chk("pend b.r1", bus_b.r_data1, 32'hCAFE_0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst a.r1", bus_a.r_data1, 32'd0);
        chk("arst b.r2", bus_b.r_data2, 32'd0);
        chk("arst a.err", {31'd0, bus_a.sel_err}, 32'd0);
        m_clear();
        @(posedge clk);
        #1;
        chk("arst hold a.r2", bus_a.r_data2, 32'd0);
        chk("arst hold b.r1", bus_b.r_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{1'b0, 32'h0, 32'h0, 31, 31, 32'h0, 32'h0, 1'b0};
        cycle(rv, 1'b1, "post_rst");

        for (int i = 0; i < 300; i++) begin
            rv = rand_vec(1'b1);
            cycle(rv, 1'b0, "rand2");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
